// File: rtl/uart_cfg.sv
// uart_cfg -- configurable full-duplex UART with 16x oversampling.
//
// Purpose: one transmitter and one receiver. Both run off a runtime clock
// divisor that sets the rate of a 16x oversample tick, so every serial bit
// lasts 16 ticks. The frame format (parity mode, one or two stop bits) is
// captured when each frame starts.
//
// Optional feature macro: UART_CFG_PARITY_EN
//   defined   -> even/odd parity generation and checking, PARITY states exist
//   undefined -> parity_mode_i ignored, rx_parity_err_o tied 0
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   div_i               clk_i cycles per oversample tick (0 and 1 mean every cycle)
//   parity_mode_i       00 none, 01 even, 10 odd, 11 none
//   stop2_i             0 = one stop bit, 1 = two stop bits
//   rx_i                asynchronous serial input
//   rx_ready_i          consumer accepts the held word
//   rx_valid_o          received word held
//   rx_data_o           received word, LSB first on the line
//   rx_frame_err_o      a stop sample was 0
//   rx_parity_err_o     parity mismatch
//   rx_overrun_o        an unread word was overwritten
//   tx_valid_i/tx_data_i/tx_ready_o  transmit handshake
//   tx_o                serial output, idles high
//   tx_done_tick_o      one-cycle pulse on the last cycle of the final stop bit
module uart_cfg #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_W-1:0]     div_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 stop2_i,
  input  logic                 rx_i,
  input  logic                 rx_ready_i,
  output logic                 rx_valid_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_overrun_o,
  input  logic                 tx_valid_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 tx_done_tick_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_CFG_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);

  // Receive tick is free running. The divisor is captured at each wrap so a
  // new div_i never truncates or overruns a count already in progress.
  logic [DIV_W-1:0] rx_div_cnt_q, rx_div_q;
  logic             rx_tick;
  assign rx_tick = (rx_div_q <= DIV_W'(1)) || (rx_div_cnt_q == rx_div_q - DIV_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || rx_tick) begin
      rx_div_cnt_q <= '0;
      rx_div_q     <= div_i;
    end else begin
      rx_div_cnt_q <= rx_div_cnt_q + DIV_W'(1);
    end
  end

  // Transmit tick restarts at the handshake so that the start bit, and with
  // it every following bit, is exactly 16 ticks long.
  logic [DIV_W-1:0] tx_div_cnt_q, tx_div_q;
  logic             tx_tick, tx_start;
  assign tx_tick = (tx_div_q <= DIV_W'(1)) || (tx_div_cnt_q == tx_div_q - DIV_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || tx_start || tx_tick) begin
      tx_div_cnt_q <= '0;
      tx_div_q     <= div_i;
    end else begin
      tx_div_cnt_q <= tx_div_cnt_q + DIV_W'(1);
    end
  end

  // Two-flop synchronizer; reset to the idle line level.
  logic [1:0] rx_sync_q;
  logic       rx_s;
  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) rx_sync_q <= 2'b11;
    else       rx_sync_q <= {rx_sync_q[0], rx_i};
  end

  // ---------------- transmitter ----------------
  state_e               tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d, tx_bcnt_q, tx_bcnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_stop2_q, tx_stop2_d;
  logic                 tx_bit_end;
`ifdef UART_CFG_PARITY_EN
  logic                 tx_par_q, tx_par_d, tx_paren_q, tx_paren_d;
`endif

  assign tx_start   = (tx_state_q == ST_IDLE) && tx_valid_i;
  assign tx_bit_end = tx_tick && (tx_tcnt_q == 4'd15);

  always_comb begin
    tx_state_d     = tx_state_q;
    tx_tcnt_d      = tx_tcnt_q;
    tx_bcnt_d      = tx_bcnt_q;
    tx_shift_d     = tx_shift_q;
    tx_stop2_d     = tx_stop2_q;
`ifdef UART_CFG_PARITY_EN
    tx_par_d       = tx_par_q;
    tx_paren_d     = tx_paren_q;
`endif
    tx_ready_o     = 1'b0;
    tx_o           = 1'b1;
    tx_done_tick_o = 1'b0;
    if (tx_tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_state_q)
      ST_IDLE: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) begin
          tx_state_d = ST_START;
          tx_shift_d = tx_data_i;
          tx_stop2_d = stop2_i;
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
`ifdef UART_CFG_PARITY_EN
          tx_paren_d = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
          tx_par_d   = (^tx_data_i) ^ (parity_mode_i == 2'b10);
`endif
        end
      end
      ST_START: begin
        tx_o = 1'b0;
        if (tx_bit_end) tx_state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_o = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bcnt_d  = tx_bcnt_q + 4'd1;
          if (tx_bcnt_q == LastBit) begin
            tx_bcnt_d  = '0;
`ifdef UART_CFG_PARITY_EN
            tx_state_d = tx_paren_q ? ST_PARITY : ST_STOP;
`else
            tx_state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_CFG_PARITY_EN
      ST_PARITY: begin
        tx_o = tx_par_q;
        if (tx_bit_end) tx_state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // tx_bcnt counts completed stop bits here.
        if (tx_bit_end) begin
          if (tx_stop2_q && (tx_bcnt_q == 4'd0)) begin
            tx_bcnt_d = 4'd1;
          end else begin
            tx_done_tick_o = 1'b1;
            tx_state_d     = ST_IDLE;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= ST_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_stop2_q <= 1'b0;
`ifdef UART_CFG_PARITY_EN
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
      tx_stop2_q <= tx_stop2_d;
`ifdef UART_CFG_PARITY_EN
      tx_par_q   <= tx_par_d;
      tx_paren_q <= tx_paren_d;
`endif
    end
  end

  // ---------------- receiver ----------------
  state_e               rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d, rx_bcnt_q, rx_bcnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_stop2_q, rx_stop2_d, rx_ferr_q, rx_ferr_d;
  logic                 rx_sample, rx_done, rx_done_ferr;
`ifdef UART_CFG_PARITY_EN
  logic                 rx_paren_q, rx_paren_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
`endif

  // START tracks ticks from the falling edge; 16 ticks after its 8th tick
  // land at the centre of each following bit.
  assign rx_sample = rx_tick && (rx_tcnt_q == 4'd15);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tcnt_d    = rx_tcnt_q;
    rx_bcnt_d    = rx_bcnt_q;
    rx_shift_d   = rx_shift_q;
    rx_stop2_d   = rx_stop2_q;
    rx_ferr_d    = rx_ferr_q;
`ifdef UART_CFG_PARITY_EN
    rx_paren_d   = rx_paren_q;
    rx_odd_d     = rx_odd_q;
    rx_perr_d    = rx_perr_q;
`endif
    rx_done      = 1'b0;
    rx_done_ferr = 1'b0;
    if (rx_tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          rx_state_d = ST_START;
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_ferr_d  = 1'b0;
          rx_stop2_d = stop2_i;
`ifdef UART_CFG_PARITY_EN
          rx_perr_d  = 1'b0;
          rx_paren_d = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
          rx_odd_d   = (parity_mode_i == 2'b10);
`endif
        end
      end
      ST_START: begin
        // A start bit that is gone by mid-bit is treated as a glitch.
        if (rx_tick && (rx_tcnt_q == 4'd7)) begin
          rx_tcnt_d  = '0;
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          rx_bcnt_d  = rx_bcnt_q + 4'd1;
          if (rx_bcnt_q == LastBit) begin
            rx_bcnt_d  = '0;
`ifdef UART_CFG_PARITY_EN
            rx_state_d = rx_paren_q ? ST_PARITY : ST_STOP;
`else
            rx_state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_CFG_PARITY_EN
      ST_PARITY: begin
        if (rx_sample) begin
          rx_perr_d  = rx_s ^ (^rx_shift_q) ^ rx_odd_q;
          rx_state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (rx_sample) begin
          rx_ferr_d = rx_ferr_q | ~rx_s;
          if (rx_stop2_q && (rx_bcnt_q == 4'd0)) begin
            rx_bcnt_d = 4'd1;
          end else begin
            rx_done      = 1'b1;
            rx_done_ferr = rx_ferr_q | ~rx_s;
            rx_state_d   = ST_IDLE;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= ST_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
      rx_stop2_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_CFG_PARITY_EN
      rx_paren_q <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
      rx_stop2_q <= rx_stop2_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_CFG_PARITY_EN
      rx_paren_q <= rx_paren_d;
      rx_odd_q   <= rx_odd_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  // Output holding register. A completion always wins over the handshake so
  // a word arriving on the accept cycle is kept; overrun marks only a word
  // that replaced one nobody read.
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_frame_err_q, rx_overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end else if (rx_done) begin
      rx_data_q      <= rx_shift_q;
      rx_valid_q     <= 1'b1;
      rx_frame_err_q <= rx_done_ferr;
      rx_overrun_q   <= rx_valid_q && !rx_ready_i;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end
  end

`ifdef UART_CFG_PARITY_EN
  logic rx_parity_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)        rx_parity_err_q <= 1'b0;
    else if (rx_done) rx_parity_err_q <= rx_perr_q;
  end

  assign rx_parity_err_o = rx_parity_err_q;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode_i;
  assign rx_parity_err_o    = 1'b0;
`endif

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_frame_err_q;
  assign rx_overrun_o   = rx_overrun_q;

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg -- directed self-checking bench for uart_cfg (DATA_BITS=8).
// Expected bit patterns and frame lengths are computed by hand from a divisor
// of 4 (64 cycles per bit) unless stated otherwise.
module tb_uart_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic [1:0]  parityMode;
  logic        stop2;
  logic        rxDrv;
  logic        lbSel;
  logic        rxReady;
  logic        txValid;
  logic [7:0]  txData;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxFerr, rxPerr, rxOvr;
  logic        txReady, txO, txDone;
  logic        rxLine;

  int checks = 0;
  int errors = 0;

  logic [15:0] bits;
  int          doneCnt, doneAt;

  always #5 clk = ~clk;

  // Loopback selects the transmitter as the receive line.
  assign rxLine = lbSel ? txO : rxDrv;

  uart_cfg #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .div_i(div), .parity_mode_i(parityMode),
    .stop2_i(stop2), .rx_i(rxLine), .rx_ready_i(rxReady),
    .rx_valid_o(rxValid), .rx_data_o(rxData), .rx_frame_err_o(rxFerr),
    .rx_parity_err_o(rxPerr), .rx_overrun_o(rxOvr),
    .tx_valid_i(txValid), .tx_data_i(txData), .tx_ready_o(txReady),
    .tx_o(txO), .tx_done_tick_o(txDone)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Handshake one transmit word; returns on the first cycle of the start bit.
  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    txValid = 1'b1;
    txData  = data;
    @(negedge clk);
    txValid = 1'b0;
  endtask

  // Samples tx_o at the centre of each bit and records done pulses.
  task automatic measureTxFrame(input int bitLen, input int nCycles, input int stop2FlipAt,
                                output logic [15:0] b, output int dc, output int da);
    b  = '1;
    dc = 0;
    da = -1;
    for (int i = 0; i < nCycles; i++) begin
      if (i == stop2FlipAt) stop2 = ~stop2;
      if (((i % bitLen) == bitLen / 2) && ((i / bitLen) < 16)) b[i / bitLen] = txO;
      if (txDone) begin
        dc++;
        da = i;
      end
      @(negedge clk);
    end
  endtask

  // Drives a frame LSB first, 64 cycles per bit, the last bit shortened.
  task automatic driveRxFrame(input logic [15:0] fb, input int n, input int lastLen);
    for (int k = 0; k < n; k++) begin
      rxDrv = fb[k];
      repeat ((k == n - 1) ? lastLen : 64) @(negedge clk);
    end
    rxDrv = 1'b1;
  endtask

  task automatic rxHandshake();
    @(negedge clk);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
  endtask

  initial begin
    rst = 1'b1; div = 16'd4; parityMode = 2'b00; stop2 = 1'b0;
    rxDrv = 1'b1; lbSel = 1'b1; rxReady = 1'b0; txValid = 1'b0; txData = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_o", txO, 1);
    checkOutput("rst_tx_ready", txReady, 1);
    checkOutput("rst_tx_done", txDone, 0);
    checkOutput("rst_rx_valid", rxValid, 0);
    checkOutput("rst_rx_data", rxData, 0);
    checkOutput("rst_rx_flags", {rxFerr, rxPerr, rxOvr}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0x55 loopback, no parity, one stop bit
    $display("[TB] loopback 0x55");
    applyStimulus(8'h55);
    checkOutput("t1_ready_busy", txReady, 0);
    measureTxFrame(64, 700, -1, bits, doneCnt, doneAt);
    checkOutput("t1_bits", bits[10:0], {2'b11, 8'h55, 1'b0});
    checkOutput("t1_done_cnt", doneCnt, 1);
    checkOutput("t1_done_at", doneAt, 639);
    checkOutput("t1_tx_ready", txReady, 1);
    checkOutput("t1_rx_valid", rxValid, 1);
    checkOutput("t1_rx_data", rxData, 8'h55);
    checkOutput("t1_rx_flags", {rxFerr, rxPerr, rxOvr}, 0);
    rxHandshake();
    checkOutput("t1_rx_cleared", rxValid, 0);

    // Two stop bits: 11-bit frame; stop2_i flipped mid-frame is ignored
    $display("[TB] two stop bits");
    stop2 = 1'b1;
    applyStimulus(8'h00);
    measureTxFrame(64, 760, 100, bits, doneCnt, doneAt);
    checkOutput("t2_bits", bits[11:0], {3'b111, 8'h00, 1'b0});
    checkOutput("t2_done_cnt", doneCnt, 1);
    checkOutput("t2_done_at", doneAt, 703);
    checkOutput("t2_rx_valid", rxValid, 1);
    checkOutput("t2_rx_data", rxData, 8'h00);
    checkOutput("t2_rx_ferr", rxFerr, 0);
    rxHandshake();

    // Second stop bit driven low -> frame error
    $display("[TB] stop2 frame error");
    lbSel = 1'b0;
    stop2 = 1'b1;
    @(negedge clk);
    driveRxFrame({5'b00000, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, 44);
    repeat (60) @(negedge clk);
    checkOutput("t3_rx_valid", rxValid, 1);
    checkOutput("t3_rx_data", rxData, 8'h5A);
    checkOutput("t3_rx_ferr", rxFerr, 1);
    rxHandshake();
    stop2 = 1'b0;

`ifdef UART_CFG_PARITY_EN
    // Parity bit generation and checking
    $display("[TB] parity");
    lbSel = 1'b1;
    parityMode = 2'b01;
    applyStimulus(8'h07);
    measureTxFrame(64, 760, -1, bits, doneCnt, doneAt);
    checkOutput("t4_even_bits", bits[10:0], {1'b1, 1'b1, 8'h07, 1'b0});
    checkOutput("t4_even_done_at", doneAt, 703);
    checkOutput("t4_even_rx", {rxValid, rxPerr, rxData}, {2'b10, 8'h07});
    rxHandshake();
    parityMode = 2'b10;
    applyStimulus(8'h07);
    measureTxFrame(64, 760, -1, bits, doneCnt, doneAt);
    checkOutput("t4_odd_bits", bits[10:0], {1'b1, 1'b0, 8'h07, 1'b0});
    checkOutput("t4_odd_rx", {rxValid, rxPerr, rxData}, {2'b10, 8'h07});
    rxHandshake();
    lbSel = 1'b0;
    parityMode = 2'b01;
    @(negedge clk);
    driveRxFrame({5'b00000, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 64);
    repeat (20) @(negedge clk);
    checkOutput("t4_inject_valid", rxValid, 1);
    checkOutput("t4_inject_perr", rxPerr, 1);
    checkOutput("t4_inject_data", rxData, 8'h07);
    rxHandshake();
    parityMode = 2'b00;
`else
    // Parity disabled: parity_mode_i must not change the frame
    $display("[TB] parity mode ignored");
    lbSel = 1'b1;
    parityMode = 2'b01;
    applyStimulus(8'h07);
    measureTxFrame(64, 700, -1, bits, doneCnt, doneAt);
    checkOutput("t4_bits", bits[10:0], {2'b11, 8'h07, 1'b0});
    checkOutput("t4_done_at", doneAt, 639);
    checkOutput("t4_rx", {rxValid, rxPerr, rxData}, {2'b10, 8'h07});
    rxHandshake();
    parityMode = 2'b00;
`endif

    // Glitch of 3 ticks is rejected
    $display("[TB] glitch reject");
    lbSel = 1'b0;
    @(negedge clk);
    rxDrv = 1'b0;
    repeat (12) @(negedge clk);
    rxDrv = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("t5_no_valid", rxValid, 0);

    // Overrun: two frames without reading
    $display("[TB] overrun");
    driveRxFrame({6'b000000, 1'b1, 8'hA1, 1'b0}, 10, 64);
    repeat (20) @(negedge clk);
    checkOutput("t6_first", {rxValid, rxOvr, rxData}, {2'b10, 8'hA1});
    driveRxFrame({6'b000000, 1'b1, 8'h3C, 1'b0}, 10, 64);
    repeat (20) @(negedge clk);
    checkOutput("t6_second_data", rxData, 8'h3C);
    checkOutput("t6_second_ovr", {rxValid, rxOvr}, 2'b11);
    rxHandshake();
    checkOutput("t6_cleared", {rxValid, rxOvr}, 2'b00);

    // Divisor 1: tick every cycle, 16 cycles per bit
    $display("[TB] divisor 1");
    lbSel = 1'b1;
    div = 16'd1;
    repeat (10) @(negedge clk);
    applyStimulus(8'hC3);
    measureTxFrame(16, 200, -1, bits, doneCnt, doneAt);
    checkOutput("t7_bits", bits[10:0], {2'b11, 8'hC3, 1'b0});
    checkOutput("t7_done_at", doneAt, 159);
    checkOutput("t7_rx", {rxValid, rxData}, {1'b1, 8'hC3});
    rxHandshake();
    div = 16'd4;
    repeat (20) @(negedge clk);

    // Reset during data bit 3 aborts the frame
    $display("[TB] reset mid-frame");
    lbSel = 1'b0;
    applyStimulus(8'hF0);
    repeat (280) @(negedge clk);
    checkOutput("t8_pre_tx_o", txO, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t8_tx_o", txO, 1);
    checkOutput("t8_tx_ready", txReady, 1);
    checkOutput("t8_tx_done", txDone, 0);
    rst = 1'b0;
    measureTxFrame(64, 800, -1, bits, doneCnt, doneAt);
    checkOutput("t8_no_done", doneCnt, 0);
    checkOutput("t8_rx_valid", rxValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
